// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, adjustable sync, blanking and gated colour register
module video_timing_gen #(
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 56,
  parameter int V_ACTIVE = 192,
  parameter int V_FP     = 28,
  parameter int V_SYNC   = 8,
  parameter int V_BP     = 36,
  parameter int COLOR_W  = 12,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               ce_pix,
  input  logic [3:0]         h_adj,
  input  logic [3:0]         v_adj,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [8:0]         hpos,
  output logic [8:0]         vpos,
  output logic               hblank,
  output logic               vblank,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               line_start,
  output logic               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_FP < 8 || H_BP < 8 || V_FP < 8 || V_BP < 8) begin : g_porch_err
    $error("video_timing_gen: porches must be at least 8");
  end
  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_total_err
    $error("video_timing_gen: totals must not exceed 512");
  end
  logic [3:0] ha, va;
  logic       h_end, v_end, hb, vb, hs_raw, vs_raw;
  logic [9:0] hs_start, vs_start;
  // Decode the live counters; adjust is sign-extended so the sum stays positive in 10 bits
  always_comb begin
    h_end    = hpos == 9'(H_TOTAL - 1);
    v_end    = vpos == 9'(V_TOTAL - 1);
    hb       = hpos >= 9'(H_ACTIVE);
    vb       = vpos >= 9'(V_ACTIVE);
    hs_start = 10'(H_ACTIVE + H_FP) + {{6{ha[3]}}, ha};
    vs_start = 10'(V_ACTIVE + V_FP) + {{6{va[3]}}, va};
    hs_raw   = {1'b0, hpos} >= hs_start && {1'b0, hpos} < hs_start + 10'(H_SYNC);
    vs_raw   = {1'b0, vpos} >= vs_start && {1'b0, vpos} < vs_start + 10'(V_SYNC);
  end
  // Counters, per-frame adjust latch and one-pixel output register, all gated by ce_pix
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hpos    <= '0;
      vpos    <= '0;
      ha      <= '0;
      va      <= '0;
      hblank  <= 1'b1;
      vblank  <= 1'b1;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
      de      <= 1'b0;
      rgb_out <= '0;
    end else if (ce_pix) begin
      hpos    <= h_end ? '0 : hpos + 9'd1;
      if (h_end) vpos <= v_end ? '0 : vpos + 9'd1;
      if (h_end && v_end) begin
        ha <= h_adj;
        va <= v_adj;
      end
      hblank  <= hb;
      vblank  <= vb;
      hsync   <= hs_raw ^ ~HS_POL;
      vsync   <= vs_raw ^ ~VS_POL;
      de      <= ~(hb | vb);
      rgb_out <= (hb | vb) ? '0 : rgb_in;
    end
  end
  // Pulses last exactly one clk_sys after the wrapping ce_pix, independent of later ce_pix
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ce_pix && h_end;
      frame_start <= ce_pix && h_end && v_end;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of a reduced raster (36x26 totals)
module tb_video_timing_gen;
  localparam int HA = 16, HF = 8, HS = 4, HB = 8;
  localparam int VA = 8, VF = 8, VS = 2, VB = 8;
  logic        clk_sys = 1'b0, rst_n = 1'b0, ce_pix = 1'b0;
  logic [3:0]  h_adj = 4'd0, v_adj = 4'd0;
  logic [11:0] rgb_in = 12'hFFF, rgb_out;
  logic [8:0]  hpos, vpos;
  logic        hblank, vblank, hsync, vsync, de, line_start, frame_start;
  int vectors = 0, errs = 0;
  int n_ce, n_de, n_ls, n_fs, n_rgb, n_leak, n_hs, n_vs, n_vb, cyc;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(12), .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce_pix(ce_pix), .h_adj(h_adj), .v_adj(v_adj),
    .rgb_in(rgb_in), .hpos(hpos), .vpos(vpos), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    ce_pix = 1'b1;
    while (!(hpos == 9'(h) && vpos == 9'(v)) && n < 2000) begin
      tick();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", h, v), 32'(n < 2000), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 0);
    chk("rst_ls", line_start, 0);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    ce_pix = 1'b1;
    tick();
    chk("first_hpos", hpos, 1);
    chk("first_de", de, 1);
    chk("first_rgb", rgb_out, 12'hFFF);
    chk("first_hblank", hblank, 0);
    wait_pos(16, 0); chk("hb_pre", hblank, 0);
    wait_pos(17, 0); chk("hb_rise", hblank, 1); chk("hb_de", de, 0); chk("hb_rgb", rgb_out, 0);
    wait_pos(24, 0); chk("hs_pre", hsync, 1);
    wait_pos(25, 0); chk("hs_first", hsync, 0);
    wait_pos(28, 0); chk("hs_last", hsync, 0);
    wait_pos(29, 0); chk("hs_post", hsync, 1);
    wait_pos(35, 0); chk("ls_pre", line_start, 0);
    wait_pos(0, 1); chk("ls_pulse", line_start, 1); chk("ls_no_fs", frame_start, 0);
    tick(); chk("ls_drop", line_start, 0);
    wait_pos(0, 8); chk("vb_pre", vblank, 0);
    wait_pos(1, 8); chk("vb_rise", vblank, 1);
    wait_pos(0, 16); chk("vs_pre", vsync, 0);
    wait_pos(1, 16); chk("vs_first", vsync, 1);
    wait_pos(1, 18); chk("vs_post", vsync, 0);
    wait_pos(0, 0); chk("fs_pulse", frame_start, 1); chk("fs_ls", line_start, 1);
    {n_fs, n_ls, n_de, n_rgb, n_leak, n_hs, n_vs, n_vb} = '0;
    for (int i = 0; i < 936; i++) begin
      tick();
      n_fs += int'(frame_start);
      n_ls += int'(line_start);
      n_de += int'(de);
      n_rgb += int'(rgb_out == 12'hFFF);
      n_leak += int'(!de && rgb_out != 0);
      n_hs += int'(!hsync);
      n_vs += int'(vsync);
      n_vb += int'(vblank);
    end
    chk("frame_fs", n_fs, 1);
    chk("frame_fs_last", frame_start, 1);
    chk("frame_ls", n_ls, 26);
    chk("frame_de", n_de, 128);
    chk("frame_rgb", n_rgb, 128);
    chk("frame_leak", n_leak, 0);
    chk("frame_hs", n_hs, 104);
    chk("frame_vs", n_vs, 72);
    chk("frame_vb", n_vb, 648);
    wait_pos(1, 3); h_adj = 4'b1000;
    wait_pos(24, 3); chk("adj_mid_pre", hsync, 1);
    wait_pos(25, 3); chk("adj_mid_old", hsync, 0);
    wait_pos(0, 0);
    wait_pos(16, 0); chk("hm8_pre", hsync, 1);
    wait_pos(17, 0); chk("hm8_first", hsync, 0);
    wait_pos(20, 0); chk("hm8_last", hsync, 0);
    wait_pos(21, 0); chk("hm8_post", hsync, 1);
    h_adj = 4'd7;
    wait_pos(17, 1); chk("hp7_held", hsync, 0);
    wait_pos(0, 0);
    wait_pos(31, 0); chk("hp7_pre", hsync, 1);
    wait_pos(32, 0); chk("hp7_first", hsync, 0);
    wait_pos(35, 0); chk("hp7_last", hsync, 0);
    wait_pos(0, 1); chk("hp7_post", hsync, 1);
    h_adj = 4'd0; v_adj = 4'd7;
    wait_pos(0, 0);
    wait_pos(1, 22); chk("vp7_pre", vsync, 0);
    wait_pos(0, 23); chk("vp7_edge", vsync, 0);
    wait_pos(1, 23); chk("vp7_first", vsync, 1);
    wait_pos(0, 25); chk("vp7_last", vsync, 1);
    wait_pos(1, 25); chk("vp7_post", vsync, 0);
    v_adj = 4'b1000;
    wait_pos(0, 0);
    wait_pos(1, 7); chk("vm8_pre", vsync, 0);
    wait_pos(1, 8); chk("vm8_first", vsync, 1);
    wait_pos(1, 10); chk("vm8_post", vsync, 0);
    wait_pos(34, 10);
    tick();
    ce_pix = 1'b0;
    n_ls = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_ls += int'(line_start);
    end
    chk("gap_hpos", hpos, 35);
    chk("gap_vpos", vpos, 10);
    chk("gap_hblank", hblank, 1);
    chk("gap_vblank", vblank, 1);
    chk("gap_hsync", hsync, 1);
    chk("gap_de", de, 0);
    chk("gap_ls", n_ls, 0);
    ce_pix = 1'b1; tick();
    chk("gap_wrap_h", hpos, 0); chk("gap_wrap_v", vpos, 11); chk("gap_ls_pulse", line_start, 1);
    ce_pix = 1'b0; tick();
    chk("gap_ls_once", line_start, 0); chk("gap_hold0", hpos, 0);
    cyc = 0;
    while (!frame_start && cyc < 20000) begin
      ce_pix = (cyc % 4 == 0);
      tick();
      cyc++;
    end
    chk("stall_fs_seen", frame_start, 1);
    {n_ce, n_de, n_ls, n_fs} = '0;
    cyc = 0;
    do begin
      ce_pix = (cyc % 4 == 0);
      tick();
      n_ce += int'(ce_pix);
      n_de += int'(ce_pix && de);
      n_ls += int'(line_start);
      n_fs += int'(frame_start);
      cyc++;
    end while (!frame_start && cyc < 8000);
    chk("stall_ce", n_ce, 936);
    chk("stall_de", n_de, 128);
    chk("stall_ls", n_ls, 26);
    chk("stall_fs", n_fs, 1);
    wait_pos(20, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hpos", hpos, 0);
    chk("arst_vpos", vpos, 0);
    chk("arst_hblank", hblank, 1);
    chk("arst_de", de, 0);
    chk("arst_rgb", rgb_out, 0);
    chk("arst_hsync", hsync, 1);
    tick();
    chk("arst_hold", hpos, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_hpos", hpos, 1);
    chk("rel_vpos", vpos, 0);
    chk("rel_de", de, 1);
    wait_pos(1, 8); chk("rel_va_clear", vsync, 0);
    wait_pos(1, 16); chk("rel_vs", vsync, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
